// File: rtl/seg7_pkg.sv
// Shared constants for the counter display: segment patterns, conversion
// state encoding and digit-index width.
package seg7_pkg;

    localparam int unsigned DIGIT_IDX_W = 2;

    // Active-high {g,f,e,d,c,b,a} patterns; polarity is applied at the pins.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_PATTERN [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Non-decimal nibbles decode to blank rather than a garbage glyph.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_PATTERN[digit];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits.
// One sampling edge, eight shift edges, one commit edge.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value_in,
    output logic [11:0] bcd_out,
    output logic        busy
);

    conv_state_t state, state_nxt;
    logic [7:0]  last_value, last_value_nxt;
    logic [7:0]  bin, bin_nxt;
    logic [11:0] acc, acc_nxt, acc_adj;
    logic [2:0]  shift_cnt, shift_cnt_nxt;
    logic [11:0] bcd_out_nxt;
    logic        busy_nxt;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_value <= '0;
            bin        <= '0;
            acc        <= '0;
            shift_cnt  <= '0;
            bcd_out    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_value <= last_value_nxt;
            bin        <= bin_nxt;
            acc        <= acc_nxt;
            shift_cnt  <= shift_cnt_nxt;
            bcd_out    <= bcd_out_nxt;
            busy       <= busy_nxt;
        end
    end

    // Add-3 correction on every nibble >= 5 ahead of the shift.
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath control; bcd_out only moves on DONE.
    always_comb begin
        state_nxt      = state;
        last_value_nxt = last_value;
        bin_nxt        = bin;
        acc_nxt        = acc;
        shift_cnt_nxt  = shift_cnt;
        bcd_out_nxt    = bcd_out;
        busy_nxt       = busy;
        case (state)
            IDLE: begin
                if (value_in != last_value) begin
                    last_value_nxt = value_in;
                    bin_nxt        = value_in;
                    acc_nxt        = '0;
                    shift_cnt_nxt  = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = SHIFT;
                end
            end
            SHIFT: begin
                {acc_nxt, bin_nxt} = {acc_adj, bin} << 1;
                shift_cnt_nxt      = shift_cnt + 3'd1;
                if (shift_cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bcd_out_nxt = acc;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/count_seg7_display.sv
// Counter value display: BCD conversion plus 4-digit multiplexed 7-segment
// drive with leading-zero blanking.
module count_seg7_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value_in,
    output logic [11:0] bcd_out,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0]       refresh_cnt;
    logic [DIGIT_IDX_W-1:0] digit_idx;
    logic [6:0]             seg_on;
    logic [3:0]             an_on;
    logic [3:0]             hundreds, tens, units;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .bcd_out  (bcd_out),
        .busy     (busy)
    );

    assign hundreds = bcd_out[11:8];
    assign tens     = bcd_out[7:4];
    assign units    = bcd_out[3:0];

    // Refresh timer: hold each digit for REFRESH_DIV cycles, then advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Select digit and apply leading-zero blanking (active-high view).
    always_comb begin
        seg_on = SEG_BLANK;
        an_on  = '0;
        case (digit_idx)
            2'd0: begin
                seg_on = seg_decode(units);
                an_on  = 4'b0001;
            end
            2'd1: begin
                if (hundreds != 4'd0 || tens != 4'd0) begin
                    seg_on = seg_decode(tens);
                    an_on  = 4'b0010;
                end
            end
            2'd2: begin
                if (hundreds != 4'd0) begin
                    seg_on = seg_decode(hundreds);
                    an_on  = 4'b0100;
                end
            end
            default: begin
            end
        endcase
        // An undecodable nibble blanks the whole digit, enable included.
        if (seg_on == SEG_BLANK) begin
            an_on = '0;
        end
    end

    // Pin registers with polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= {7{ACTIVE_LOW}};
            an  <= {4{ACTIVE_LOW}};
        end else begin
            seg <= ACTIVE_LOW ? ~seg_on : seg_on;
            an  <= ACTIVE_LOW ? ~an_on : an_on;
        end
    end

endmodule

// File: tb/tb_count_seg7_display.sv
// Directed bench for count_seg7_display with REFRESH_DIV = 4, ACTIVE_LOW = 1.
module tb_count_seg7_display;

    logic        clk;
    logic        reset;
    logic [7:0]  value_in;
    logic [11:0] bcd_out;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    count_seg7_display #(
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .bcd_out  (bcd_out),
        .busy     (busy),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watch one full refresh period (4 digits x 4 cycles) and record what
    // each enable showed; flag ghosting, inconsistent segments or lit-off segs.
    task automatic scan(output logic [3:0] seen, output logic [3:0][6:0] seg_seen, output int bad);
        logic [3:0] act;
        seen     = '0;
        seg_seen = '0;
        bad      = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            act = ~an;
            if ($countones(act) > 1) begin
                bad++;
            end else if (act == 4'b0000) begin
                if (seg !== 7'h7F) bad++;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (act[k]) begin
                        if (seen[k] && seg_seen[k] !== seg) bad++;
                        seen[k]     = 1'b1;
                        seg_seen[k] = seg;
                    end
                end
            end
        end
    endtask

    task automatic check_display(input string tag, input logic [3:0] exp_seen,
                                 input logic [6:0] exp_u, input logic [6:0] exp_t,
                                 input logic [6:0] exp_h);
        logic [3:0]      seen;
        logic [3:0][6:0] seg_seen;
        int              bad;
        scan(seen, seg_seen, bad);
        check({tag, "_glitch"}, bad, 0);
        check({tag, "_enables"}, {28'd0, seen}, {28'd0, exp_seen});
        if (exp_seen[0]) check({tag, "_units"}, {25'd0, seg_seen[0]}, {25'd0, exp_u});
        if (exp_seen[1]) check({tag, "_tens"}, {25'd0, seg_seen[1]}, {25'd0, exp_t});
        if (exp_seen[2]) check({tag, "_hund"}, {25'd0, seg_seen[2]}, {25'd0, exp_h});
    endtask

    initial begin
        reset    = 1'b1;
        value_in = 8'd0;

        // 1: reset state, then idle display of 0
        step(3);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bcd", {20'd0, bcd_out}, 32'h000);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            check("zero_an", {28'd0, an}, (i < 4) ? 32'hE : 32'hF);
            check("zero_seg", {25'd0, seg}, (i < 4) ? 32'h40 : 32'h7F);
        end

        // 2: 0 -> 255, exact latency
        value_in = 8'd255;
        step(1);
        check("c255_busy0", {31'd0, busy}, 32'd1);
        check("c255_bcd0", {20'd0, bcd_out}, 32'h000);
        for (int e = 1; e <= 8; e++) begin
            step(1);
            check("c255_busy_mid", {31'd0, busy}, 32'd1);
            check("c255_bcd_mid", {20'd0, bcd_out}, 32'h000);
        end
        step(1);
        check("c255_bcd", {20'd0, bcd_out}, 32'h255);
        check("c255_busy", {31'd0, busy}, 32'd0);
        check_display("d255", 4'b0111, 7'h12, 7'h12, 7'h24);

        // 3: value 7, tens and hundreds blanked
        value_in = 8'd7;
        step(10);
        check("c7_bcd", {20'd0, bcd_out}, 32'h007);
        check("c7_busy", {31'd0, busy}, 32'd0);
        check_display("d7", 4'b0001, 7'h78, 7'h7F, 7'h7F);

        // 4: value 105, inner zero shown
        value_in = 8'd105;
        step(10);
        check("c105_bcd", {20'd0, bcd_out}, 32'h105);
        check_display("d105", 4'b0111, 7'h12, 7'h40, 7'h79);

        // 5: 10, then 20 arriving at shift edge 3
        value_in = 8'd10;
        step(1);
        check("c10_busy0", {31'd0, busy}, 32'd1);
        step(2);
        check("c10_bcd_e2", {20'd0, bcd_out}, 32'h105);
        value_in = 8'd20;
        for (int e = 3; e <= 8; e++) begin
            step(1);
            check("c10_bcd_mid", {20'd0, bcd_out}, 32'h105);
            check("c10_busy_mid", {31'd0, busy}, 32'd1);
        end
        step(1);
        check("c10_bcd", {20'd0, bcd_out}, 32'h010);
        check("c10_busy", {31'd0, busy}, 32'd0);
        step(1);
        check("c20_busy0", {31'd0, busy}, 32'd1);
        for (int e = 1; e <= 8; e++) begin
            step(1);
            check("c20_bcd_mid", {20'd0, bcd_out}, 32'h010);
        end
        step(1);
        check("c20_bcd", {20'd0, bcd_out}, 32'h020);
        check("c20_busy", {31'd0, busy}, 32'd0);

        // 6: reset at shift edge 5 of 200, then reconvert
        value_in = 8'd200;
        step(1);
        check("c200_busy0", {31'd0, busy}, 32'd1);
        step(4);
        reset = 1'b1;
        step(1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {20'd0, bcd_out}, 32'h000);
        check("abort_an", {28'd0, an}, 32'hF);
        check("abort_seg", {25'd0, seg}, 32'h7F);
        reset = 1'b0;
        step(10);
        check("c200_bcd", {20'd0, bcd_out}, 32'h200);
        check("c200_busy", {31'd0, busy}, 32'd0);
        check_display("d200", 4'b0111, 7'h40, 7'h40, 7'h24);

        // Constant input: no further conversion
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("steady_busy", {31'd0, busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_seg7_display.md
Name: count_seg7_display

Overview:
- Downstream consumer of the 8-bit free-running counter value.
- Converts the unsigned binary value to three BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed 7-segment display with leading-zero blanking.
- Sits between the counter output and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays active; legal range ≥ 2.
- ACTIVE_LOW, 1: 1 means seg and an are active-low (common anode); 0 means active-high.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- value_in  in  8  unsigned binary value to display (counter output).
- bcd_out  out  12  {hundreds, tens, units} BCD of the last completed conversion.
- busy  out  1  high while a conversion is in progress.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- an  out  4  digit enables, an[0] = units, polarity per ACTIVE_LOW.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, port names clk and reset.
- All outputs are registered.
- Reset values:
  - bcd_out = 12'h000, busy = 0.
  - last_value = 0, conversion FSM = IDLE.
  - refresh counter = 0, digit index = 0.
  - an = all inactive, seg = all segments off.
- Reset asserted mid-conversion aborts it. On the next edge the reset values above apply.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: if value_in != last_value at an edge (edge 0), latch value_in into last_value and the shift register, clear the BCD accumulator, clear the shift count, set busy = 1, go to SHIFT.
  - SHIFT: each edge, first add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. Occupies edges 1..8. After the 8th shift, go to DONE.
  - DONE (edge 9): bcd_out <= accumulator, busy <= 0, go to IDLE.
  - Fixed latency: 9 edges from the sampling edge to bcd_out valid. bcd_out holds its old value until then, never a partial result.
- value_in changes while busy are ignored. On return to IDLE the compare against last_value re-triggers, so the final value is always converted.
- Constant value_in means no conversion and busy stays 0.
- Range: 0..255, so hundreds ≤ 2. Wrap from 255 to 0 is just another change.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→0.
- Digit drive (registered one edge after the index changes):
  - Index 0: units, always shown.
  - Index 1: tens, blanked if hundreds = 0 and tens = 0.
  - Index 2: hundreds, blanked if hundreds = 0.
  - Index 3: always blanked.
  - Blanked digit: its an bit is inactive and seg is all off.
  - Exactly one an bit is active at most; no ghosting.
- Segment patterns are active-high abcdefg: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - When ACTIVE_LOW = 1, both seg and an are bit-inverted.
  - BCD nibbles > 9 cannot occur. If one does, show blank.

Decomposition:
- Package seg7_pkg holds:
  - SEG_PATTERN[0..9] constants and SEG_BLANK.
  - The conversion state encoding (IDLE, SHIFT, DONE).
  - The digit-index width constant.
- One sub-module, bin2bcd_seq, contains the double-dabble FSM, busy and bcd_out.
- The top level owns the refresh counter, blanking logic and seg/an registers.

Test Plan:
All scenarios use REFRESH_DIV = 4 and ACTIVE_LOW = 1.
1. Reset held 3 cycles, value_in = 0, then released:
   - During reset: an = 4'b1111, seg = 7'h7F, busy = 0, bcd_out = 12'h000.
   - After release: units phase shows an = 4'b1110, seg = 7'h40; other phases an = 4'b1111.
2. value_in 0→255 at edge 0:
   - busy = 1 after edge 0.
   - bcd_out = 12'h255 and busy = 0 after edge 9, not earlier.
   - Display cycles through 2, 5, 5.
3. value_in = 7:
   - bcd_out = 12'h007.
   - an[1] and an[2] never go low; units seg = 7'h78.
4. value_in = 105:
   - bcd_out = 12'h105.
   - Tens digit shown as 0 (seg = 7'h40, not blanked); hundreds seg = 7'h79.
5. value_in 10 then 20 applied at shift edge 3:
   - First completion gives bcd_out = 12'h010.
   - A second conversion starts automatically; bcd_out = 12'h020 after it.
   - No intermediate value appears.
6. Reset pulsed at shift edge 5 of a conversion of 200:
   - Next edge: busy = 0, bcd_out = 12'h000, an = 4'b1111.
   - After release, value_in = 200 re-converts to 12'h200.
